branch_pc_controller: RTL and testbench
=======================================

BRANCH_PC_CONTROLLER -- requirements
Module: branch_pc_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset; bits [1:0] must be zero.
REQ-002 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port stall, input, 1: pipeline hold request from downstream.
REQ-005 SHALL have port imem_ready, input, 1: instruction memory accepts the current fetch.
REQ-006 SHALL have port branch_valid, input, 1: a branch instruction is presented for resolution this cycle.
REQ-007 SHALL have port instr_code, input, 32: branch instruction; funct3 = instr_code[14:12].
REQ-008 SHALL have ports rs1_data and rs2_data, input, 32 each: branch compare operands.
REQ-009 SHALL have port branch_pc, input, 32: address of the branch instruction.
REQ-010 SHALL have port immediate, input, 32: sign-extended B-type offset.
REQ-011 SHALL have port pc, output, 32: current fetch address.
REQ-012 SHALL have port imem_req, output, 1: fetch request for pc.
REQ-013 SHALL have port flush, output, 1: one-cycle pulse to discard younger in-flight instructions.
REQ-014 SHALL have port illegal_br, output, 1: one-cycle pulse for an unsupported funct3.
REQ-015 SHALL have port misalign_err, output, 1: sticky error flag for a misaligned taken target.

Function
REQ-016 SHALL implement states RUN, REDIRECT and HALT.
REQ-017 SHALL decode funct3 as: 000 beq; 001 bne; 100 blt signed; 101 bge signed; 110 bltu unsigned; 111 bgeu unsigned.
REQ-018 SHALL treat funct3 010/011 as not-taken and pulse illegal_br on the following cycle.
REQ-019 SHALL compute the target as branch_pc + immediate, modulo 2^32, with wrap-around permitted.
REQ-020 SHALL drive imem_req = 1 only in RUN with stall = 0.
REQ-021 SHALL, in RUN, update pc <= pc + 4 on a cycle where imem_req && imem_ready, with wrap from FFFF_FFFC to 0000_0000.
REQ-022 SHALL hold pc when stall = 1 or imem_ready = 0 and no branch is taken.
REQ-023 SHALL, on branch_valid with the branch taken in RUN, load pc <= target, pulse flush next cycle and enter REDIRECT, even if stall = 1.
REQ-024 SHALL give a taken branch priority over a fetch accepted in the same cycle, with no pc + 4 applied.
REQ-025 SHALL leave pc and state unaffected by a not-taken branch beyond the normal fetch advance.
REQ-026 SHALL hold REDIRECT for exactly one cycle with imem_req = 0, ignore branch_valid, then return to RUN.
REQ-027 SHALL, when a taken target has bits [1:0] != 0, leave pc unchanged, set misalign_err and enter HALT.
REQ-028 SHALL, in HALT, force imem_req = 0 and ignore all inputs until reset.
REQ-029 SHALL give a taken branch 1 cycle of latency to the pc update and 2 cycles to the next imem_req.

Reset
REQ-030 SHALL, on rst_n = 0 at a clock edge, set pc = RESET_PC and state = RUN, and clear flush, illegal_br and misalign_err.
REQ-031 SHALL let reset override any state, including REDIRECT and HALT, and drop an in-flight branch.

Configuration
REQ-032 SHALL, with macro BRANCH_PC_STATS_EN defined, add 32-bit outputs br_taken_cnt and br_total_cnt, reset to 0 and saturating at FFFF_FFFF.
REQ-033 SHALL count only resolved branches in RUN (branch_valid in REDIRECT or HALT not counted), with br_total_cnt incrementing on every resolved branch including illegal funct3 and br_taken_cnt only on taken ones.
REQ-034 SHALL, without BRANCH_PC_STATS_EN, omit those ports and counters entirely and leave all other behaviour identical.

Structure
REQ-035 SHALL place the funct3 encoding constants, the state enum typedef and the PC increment constant 4 in a shared package branch_pkg.
REQ-036 SHALL implement the compare in a combinational sub-module branch_cmp (inputs funct3, rs1_data, rs2_data; outputs taken, illegal), with the FSM and PC register kept in branch_pc_controller.

Verification
REQ-037 SHALL cover reset with RESET_PC = 0x100 and imem_ready held at 1: pc goes 0x100, 0x104, 0x108 on consecutive cycles.
REQ-038 SHALL cover beq with rs1 = rs2 = 5, branch_pc = 0x200 and immediate = -8: next pc = 0x1F8, flush pulses 1 cycle, and imem_req = 0 for 1 cycle.
REQ-039 SHALL cover blt with rs1 = FFFF_FFFF and rs2 = 1 (taken) versus bltu with the same operands (not taken): pc advances only by fetch.
REQ-040 SHALL cover a taken branch with stall = 1 and imem_ready = 1 in the same cycle: pc = target and no +4 is applied.
REQ-041 SHALL cover a taken target of 0x202: misalign_err = 1, pc unchanged, imem_req = 0 until rst_n = 0, then pc = RESET_PC.
REQ-042 SHALL cover funct3 = 010: illegal_br pulses, pc continues sequentially and, with BRANCH_PC_STATS_EN, br_total_cnt increments by 1.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch funct3 codes, controller state type and PC step
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluation from funct3
module branch_cmp
  import branch_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        taken,
  output logic        illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      // 010 and 011 have no branch meaning; they resolve as not-taken.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_controller.sv
// rtl/branch_pc_controller.sv - fetch PC register and RUN/REDIRECT/HALT branch FSM
// BRANCH_PC_STATS_EN adds saturating resolved/taken branch counters.
module branch_pc_controller
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_valid,
  input  logic [31:0] instr_code,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] branch_pc,
  input  logic [31:0] immediate,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        flush,
  output logic        illegal_br,
  output logic        misalign_err
`ifdef BRANCH_PC_STATS_EN
  ,
  output logic [31:0] br_taken_cnt,
  output logic [31:0] br_total_cnt
`endif
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_flush;
  logic        r_illegal;
  logic        r_misalign;

  logic        w_taken;
  logic        w_illegal;
  logic [31:0] w_target;
  logic        w_fetch;
  logic        w_resolve;
  logic        w_unused_instr;

  branch_cmp u_cmp (
    .funct3   (instr_code[14:12]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (w_taken),
    .illegal  (w_illegal)
  );

  assign w_unused_instr = ^{instr_code[31:15], instr_code[11:0]};
  assign w_target       = branch_pc + immediate;
  assign imem_req       = (r_state == ST_RUN) && !stall;
  assign w_fetch        = imem_req && imem_ready;
  assign w_resolve      = (r_state == ST_RUN) && branch_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_illegal  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_flush   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // A taken branch wins over stall and over a fetch accepted this cycle.
          if (w_resolve && w_taken) begin
            if (w_target[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= ST_HALT;
            end else begin
              r_pc    <= w_target;
              r_flush <= 1'b1;
              r_state <= ST_REDIRECT;
            end
          end else begin
            r_illegal <= w_resolve && w_illegal;
            if (w_fetch) r_pc <= r_pc + PC_INC;
          end
        end
        ST_REDIRECT: r_state <= ST_RUN;
        default:     r_state <= ST_HALT;
      endcase
    end
  end

`ifdef BRANCH_PC_STATS_EN
  logic [31:0] r_taken_cnt;
  logic [31:0] r_total_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_total_cnt <= '0;
    end else if (w_resolve) begin
      if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + 32'd1;
      if (w_taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end

  assign br_taken_cnt = r_taken_cnt;
  assign br_total_cnt = r_total_cnt;
`endif

  assign pc           = r_pc;
  assign flush        = r_flush;
  assign illegal_br   = r_illegal;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_branch_pc_controller.sv
// tb/tb_branch_pc_controller.sv - directed and randomized checks against a behavioural model
module tb_branch_pc_controller;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int M_RUN = 0, M_REDIR = 1, M_HALT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, imem_ready, branch_valid;
  logic [31:0] instr_code, rs1_data, rs2_data, branch_pc, immediate;
  logic [31:0] pc;
  logic        imem_req, flush, illegal_br, misalign_err;
`ifdef BRANCH_PC_STATS_EN
  logic [31:0] br_taken_cnt, br_total_cnt;
`endif

  branch_pc_controller #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
    .branch_valid(branch_valid), .instr_code(instr_code),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .branch_pc(branch_pc),
    .immediate(immediate), .pc(pc), .imem_req(imem_req), .flush(flush),
    .illegal_br(illegal_br), .misalign_err(misalign_err)
`ifdef BRANCH_PC_STATS_EN
    , .br_taken_cnt(br_taken_cnt), .br_total_cnt(br_total_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_tot, m_tkn;
  int          m_mode;
  logic        m_flush, m_ill, m_mis;

  function automatic bit ref_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    case (f)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk_instr(logic [2:0] f);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f;
    return r;
  endfunction

  // Advances the reference model with the inputs currently applied, then clocks the DUT.
  task automatic tick();
    logic [31:0] tgt;
    logic [2:0]  f3;
    tgt = branch_pc + immediate;
    f3  = instr_code[14:12];
    if (!rst_n) begin
      m_pc = RPC; m_mode = M_RUN; m_flush = 0; m_ill = 0; m_mis = 0; m_tot = 0; m_tkn = 0;
    end else begin
      m_flush = 0; m_ill = 0;
      if (m_mode == M_REDIR) m_mode = M_RUN;
      else if (m_mode == M_RUN) begin
        if (branch_valid && m_tot != 32'hFFFF_FFFF) m_tot = m_tot + 1;
        if (branch_valid && ref_taken(f3, rs1_data, rs2_data)) begin
          if (m_tkn != 32'hFFFF_FFFF) m_tkn = m_tkn + 1;
          if (tgt % 4 != 0) begin m_mis = 1; m_mode = M_HALT; end
          else begin m_pc = tgt; m_flush = 1; m_mode = M_REDIR; end
        end else begin
          m_ill = branch_valid && (f3 == 3'd2 || f3 == 3'd3);
          if (!stall && imem_ready) m_pc = m_pc + 4;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst_n = 1; stall = 0; imem_ready = 1; branch_valid = 0;
  endtask

  task automatic branch(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] bpc, logic [31:0] imm);
    branch_valid = 1; instr_code = mk_instr(f);
    rs1_data = a; rs2_data = b; branch_pc = bpc; immediate = imm;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 1; imem_ready = 0; branch_valid = 1;
    instr_code = mk_instr(3'd0); rs1_data = 0; rs2_data = 0; branch_pc = 0; immediate = 8;
    tick();
    n_chk++; if (pc !== RPC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, RPC); end
    n_chk++; if ({flush, illegal_br, misalign_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000", {flush, illegal_br, misalign_err}); end
    idle(); #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got %b exp 1", imem_req); end
    tick();
    n_chk++; if (pc !== 32'h104) begin n_fail++; $display("FAIL seq_104 got %h exp 104", pc); end
    tick();
    n_chk++; if (pc !== 32'h108) begin n_fail++; $display("FAIL seq_108 got %h exp 108", pc); end
  endtask

  task automatic test_beq();
    branch(3'd0, 5, 5, 32'h200, 32'hFFFF_FFF8);
    tick();
    n_chk++; if (pc !== 32'h1F8) begin n_fail++; $display("FAIL beq_pc got %h exp 1f8", pc); end
    n_chk++; if (flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush got %b exp 1", flush); end
    branch(3'd0, 1, 1, 32'h400, 32'h40); #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redirect_req got %b exp 0", imem_req); end
    tick();
    n_chk++; if (pc !== 32'h1F8) begin n_fail++; $display("FAIL redirect_ignore got %h exp 1f8", pc); end
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL flush_pulse got %b exp 0", flush); end
    idle(); #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_redirect_req got %b exp 1", imem_req); end
    tick();
    n_chk++; if (pc !== 32'h1FC) begin n_fail++; $display("FAIL post_redirect_pc got %h exp 1fc", pc); end
  endtask

  task automatic test_signed_unsigned();
    branch(3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h40);
    tick();
    n_chk++; if (pc !== 32'h340) begin n_fail++; $display("FAIL blt_taken got %h exp 340", pc); end
    idle(); tick();
    branch(3'd6, 32'hFFFF_FFFF, 1, 32'h300, 32'h40);
    tick();
    n_chk++; if (pc !== 32'h344) begin n_fail++; $display("FAIL bltu_not_taken got %h exp 344", pc); end
    n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL bltu_flush got %b exp 0", flush); end
  endtask

  task automatic test_stall_taken();
    idle(); stall = 1;
    branch(3'd1, 3, 4, 32'h500, 32'h20); #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b exp 0", imem_req); end
    tick();
    n_chk++; if (pc !== 32'h520) begin n_fail++; $display("FAIL stall_taken got %h exp 520", pc); end
    idle(); tick();
  endtask

  task automatic test_illegal();
    logic [31:0] p, tot;
    p = pc; tot = m_tot;
    branch(3'd2, 7, 7, 32'h600, 32'h10);
    tick();
    n_chk++; if (illegal_br !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse got %b exp 1", illegal_br); end
    n_chk++; if (pc !== p + 32'd4) begin n_fail++; $display("FAIL illegal_seq got %h exp %h", pc, p + 32'd4); end
`ifdef BRANCH_PC_STATS_EN
    n_chk++; if (br_total_cnt !== tot + 32'd1) begin n_fail++; $display("FAIL illegal_total got %0d exp %0d", br_total_cnt, tot + 32'd1); end
`endif
    idle(); tick();
    n_chk++; if (illegal_br !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got %b exp 0", illegal_br); end
  endtask

  task automatic test_wrap();
    branch(3'd7, 9, 9, 32'hFFFF_FFF0, 32'hC);
    tick();
    n_chk++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_tgt got %h exp fffffffc", pc); end
    idle(); tick(); tick();
    n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_seq got %h exp 0", pc); end
    branch(3'd5, 0, 32'h8000_0000, 32'hFFFF_FFF0, 32'h20);
    tick();
    n_chk++; if (pc !== 32'h10) begin n_fail++; $display("FAIL wrap_add got %h exp 10", pc); end
    idle(); tick();
  endtask

  task automatic test_misalign();
    logic [31:0] p;
    p = pc;
    branch(3'd0, 2, 2, 32'h200, 32'h2);
    tick();
    n_chk++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set got %b exp 1", misalign_err); end
    n_chk++; if (pc !== p) begin n_fail++; $display("FAIL misalign_pc got %h exp %h", pc, p); end
    for (int i = 0; i < 6; i++) begin
      stall = 0; imem_ready = 1; branch(3'd0, 1, 1, 32'h800, 32'h8); #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req got %b exp 0", imem_req); end
      tick();
      n_chk++; if (pc !== p || misalign_err !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold got pc %h err %b exp pc %h err 1", pc, misalign_err, p); end
    end
    rst_n = 0; tick();
    n_chk++; if (pc !== RPC || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset got pc %h err %b exp pc %h err 0", pc, misalign_err, RPC); end
    idle();
  endtask

  task automatic test_random();
    logic [2:0] f;
    for (int i = 0; i < 800; i++) begin
      rst_n        = ($urandom % 70) != 0;
      stall        = ($urandom % 4) == 0;
      imem_ready   = ($urandom % 4) != 0;
      branch_valid = ($urandom % 3) == 0;
      f            = 3'($urandom);
      instr_code   = mk_instr(f);
      rs1_data     = ($urandom % 2) ? 32'($urandom % 4) : $urandom;
      rs2_data     = ($urandom % 2) ? 32'($urandom % 4) : $urandom;
      branch_pc    = $urandom & 32'hFFFF_FFFC;
      immediate    = ($urandom % 25 == 0) ? $urandom
                   : (32'(int'($urandom_range(0, 4095)) - 2048) & 32'hFFFF_FFFC);
      #1;
      n_chk++; if (imem_req !== (m_mode == M_RUN && !stall)) begin
        n_fail++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, imem_req, (m_mode == M_RUN && !stall)); end
      tick();
      n_chk++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc, m_pc); end
      n_chk++; if ({flush, illegal_br, misalign_err} !== {m_flush, m_ill, m_mis}) begin
        n_fail++; $display("FAIL rnd_flags cyc %0d got %b exp %b", i,
                           {flush, illegal_br, misalign_err}, {m_flush, m_ill, m_mis}); end
`ifdef BRANCH_PC_STATS_EN
      n_chk++; if (br_total_cnt !== m_tot || br_taken_cnt !== m_tkn) begin
        n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", i,
                           br_total_cnt, br_taken_cnt, m_tot, m_tkn); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_stall_taken();
    test_illegal();
    test_wrap();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
